abc_code_sequencer: RTL and testbench

- Upstream driver for the 3-input code decoder. Generates the {A,B,C} select code that the decoder consumes.
- Steps the code from 0 to LAST_CODE. Each code is held for DWELL clock cycles.
- Supports start, pause and abort control, and reports busy/done status.
- Lets the downstream decoder outputs D0..D7 be exercised in a fixed, timed order.

---
 rtl/abc_seq_pkg.sv | 13 +
 rtl/abc_dwell_counter.sv | 27 ++
 rtl/abc_code_sequencer.sv | 108 ++++++++++
 tb/tb_abc_code_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/abc_seq_pkg.sv
// Shared types and constants for the {A,B,C} code sequencer.
package abc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CODE_W = 3;
  localparam logic [CODE_W-1:0] CODE_ZERO = 3'b000;

endpackage

// File: rtl/abc_dwell_counter.sv
// Down-counter that times how long each code is held; saturates at zero.
module abc_dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/abc_code_sequencer.sv
// Steps {A,B,C} from 000 to LAST_CODE, holding each code DWELL cycles.
// Define ABC_SEQ_WRAP_EN for continuous mode (wrap to 000, done pulse per pass).
module abc_code_sequencer
  import abc_seq_pkg::*;
#(
  parameter int DWELL     = 4,
  parameter int LAST_CODE = 7,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic pause,
  input  logic abort,
  output logic A,
  output logic B,
  output logic C,
  output logic code_valid,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(DWELL - 1);
  localparam logic [CODE_W-1:0] LAST   = CODE_W'(LAST_CODE);

  state_t            state;
  logic [CODE_W-1:0] code_q;
  logic [CNT_W-1:0]  dwell_cnt;
  logic              cnt_zero;
  logic              cnt_load;
  logic              cnt_dec;
  logic              start_ok;
  logic              run_step;
  logic              last_hit;

  assign start_ok = (state == IDLE) && start && !abort;
  assign run_step = (state == RUN) && !abort && !pause;
  assign last_hit = (code_q == LAST);
  assign cnt_dec  = run_step && (dwell_cnt != '0);
`ifdef ABC_SEQ_WRAP_EN
  assign cnt_load = start_ok || (run_step && cnt_zero);
`else
  assign cnt_load = start_ok || (run_step && cnt_zero && !last_hit);
`endif

  abc_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (RELOAD),
    .dec      (cnt_dec),
    .count    (dwell_cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      code_q     <= CODE_ZERO;
      code_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: default first so done is a one-cycle pulse rather than a held value.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state      <= RUN;
            code_q     <= CODE_ZERO;
            code_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state      <= IDLE;
            code_q     <= CODE_ZERO;
            code_valid <= 1'b0;
            busy       <= 1'b0;
          end else if (!pause && cnt_zero) begin
            if (!last_hit) begin
              code_q <= code_q + 1'b1;
            end else begin
`ifdef ABC_SEQ_WRAP_EN
              code_q <= CODE_ZERO;
              done   <= 1'b1;
`else
              state      <= DONE;
              code_q     <= CODE_ZERO;
              code_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
`endif
            end
          end
        end
`ifndef ABC_SEQ_WRAP_EN
        DONE: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign {A, B, C} = code_q;

endmodule

// File: tb/tb_abc_code_sequencer.sv
// Randomised and directed bench comparing two sequencer configurations against a timeline model.
module tb_abc_code_sequencer;

  localparam int D0 = 4;
  localparam int L0 = 7;
  localparam int D1 = 1;
  localparam int L1 = 3;

  typedef struct {
    bit run;
    bit fin;
    bit dp;
    int el;
  } mdl_t;

  logic clk = 1'b0;
  logic rst, start, pause, abort;
  logic a0, b0, c0, cv0, bz0, dn0;
  logic a1, b1, c1, cv1, bz1, dn1;
  logic [5:0] obs0, obs1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int first0   = -1;
  int first1   = -1;
  logic [5:0] snap;
  mdl_t m0, m1;

  assign obs0 = {a0, b0, c0, cv0, bz0, dn0};
  assign obs1 = {a1, b1, c1, cv1, bz1, dn1};

  always #5 clk = ~clk;

  abc_code_sequencer #(.DWELL(D0), .LAST_CODE(L0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .A(a0), .B(b0), .C(c0), .code_valid(cv0), .busy(bz0), .done(dn0)
  );

  abc_code_sequencer #(.DWELL(D1), .LAST_CODE(L1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .A(a1), .B(b1), .C(c1), .code_valid(cv1), .busy(bz1), .done(dn1)
  );

  // Run position counted in visible cycles: the code shown is elapsed / dwell.
  function automatic mdl_t mdl_next(mdl_t m, int dwell, int last, bit s, bit p, bit a, bit r);
    mdl_t n;
    n = m;
    n.dp = 1'b0;
    if (r) begin
      n.run = 1'b0; n.fin = 1'b0; n.el = 0;
    end else if (m.fin) begin
      n.fin = 1'b0;
    end else if (!m.run) begin
      if (s && !a) begin
        n.run = 1'b1; n.el = 0;
      end
    end else if (a) begin
      n.run = 1'b0;
    end else if (!p) begin
      n.el = m.el + 1;
      if (n.el == dwell * (last + 1)) begin
`ifdef ABC_SEQ_WRAP_EN
        n.el = 0; n.dp = 1'b1;
`else
        n.run = 1'b0; n.fin = 1'b1;
`endif
      end
    end
    return n;
  endfunction

  function automatic logic [5:0] mdl_out(mdl_t m, int dwell);
    logic [2:0] code;
    code = 3'(m.el / dwell);
    if (m.run)      return {code, 1'b1, 1'b1, m.dp};
    else if (m.fin) return 6'b000001;
    else            return 6'b000000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Inputs apply during cycle cyc; outputs of cycle cyc+1 are checked after the edge.
  task automatic step(input bit s, input bit p, input bit a, input bit r);
    start = s; pause = p; abort = a; rst = r;
    @(posedge clk);
    m0 = mdl_next(m0, D0, L0, s, p, a, r);
    m1 = mdl_next(m1, D1, L1, s, p, a, r);
    #1;
    cyc++;
    check("dut0_out", 32'(obs0), 32'(mdl_out(m0, D0)));
    check("dut1_out", 32'(obs1), 32'(mdl_out(m1, D1)));
    if (dn0 && first0 < 0) first0 = cyc;
    if (dn1 && first1 < 0) first1 = cyc;
  endtask

  task automatic new_scenario();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    cyc = 0; first0 = -1; first1 = -1;
  endtask

  initial begin
    m0 = '{run: 1'b0, fin: 1'b0, dp: 1'b0, el: 0};
    m1 = m0;
    start = 1'b0; pause = 1'b0; abort = 1'b0; rst = 1'b1;

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_out", 32'(obs0), 32'd0);

    // Plain run: done in cycle 33
    new_scenario();
    for (int i = 0; i < 36; i++) step(i == 0, 1'b0, 1'b0, 1'b0);
    check("run_done_cycle", first0, 33);

    // Pause three cycles while code 010 is shown
    new_scenario();
    for (int i = 0; i < 40; i++) step(i == 0, (i >= 10 && i <= 12), 1'b0, 1'b0);
    check("pause_done_cycle", first0, 36);

    // Abort on the second cycle of code 011, then a clean restart
    new_scenario();
    for (int i = 0; i < 15; i++) step(i == 0, 1'b0, i == 14, 1'b0);
    check("abort_out", 32'(obs0), 32'd0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_no_done", first0, -1);
    cyc = 0; first0 = -1; first1 = -1;
    for (int i = 0; i < 35; i++) step(i == 0, 1'b0, 1'b0, 1'b0);
    check("restart_done_cycle", first0, 33);

    // Short configuration with start pulses that must be ignored
    new_scenario();
    for (int i = 0; i < 10; i++) step(i == 0 || i == 2 || i == 5, 1'b0, 1'b0, 1'b0);
    check("short_done_cycle", first1, 5);

    // Reset mid-run, then start and abort together in IDLE
    new_scenario();
    for (int i = 0; i < 11; i++) step(i == 0, 1'b0, 1'b0, i == 10);
    check("midrun_reset_out", 32'(obs0), 32'd0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("midrun_reset_no_done", first0, -1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("start_abort_idle0", 32'(obs0), 32'd0);
    check("start_abort_idle1", 32'(obs1), 32'd0);

`ifdef ABC_SEQ_WRAP_EN
    // Continuous mode: wrap at cycle 33 with busy held, abort in cycle 40
    new_scenario();
    snap = '0;
    for (int i = 0; i < 41; i++) begin
      step(i == 0, 1'b0, i == 40, 1'b0);
      if (cyc == 33) snap = obs0;
    end
    check("wrap_cycle33", 32'(snap), 32'(6'b000111));
    check("wrap_abort_out", 32'(obs0), 32'd0);
`endif

    // Random traffic
    new_scenario();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
